// File: rtl/ring_counter_gen.sv
// Parametrised one-hot ring / Johnson counter with load, wrap pulse and illegal-state flag.
// Define RC_SELF_CORRECT_EN to restart from INIT when stepping out of an illegal state.
module ring_counter_gen #(
  parameter int              WIDTH = 4,
  parameter logic [WIDTH-1:0] INIT = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             wrap,
  output logic             illegal
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic [CW-1:0]    ones;
  logic [CW-1:0]    edges;
  logic             fb;
  logic [WIDTH-1:0] shift;

  always_comb begin
    ones  = '0;
    edges = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + CW'(q_q[i]);
    end
    for (int i = 0; i < WIDTH - 1; i++) begin
      edges = edges + CW'(q_q[i] ^ q_q[i+1]);
    end
  end

  assign illegal = mode ? (edges > CW'(1))
                        : (ones != CW'(1));

  // Johnson mode feeds back the inverted outgoing bit
  always_comb begin
    fb    = 1'b0;
    shift = q_q;
    if (!dir) begin
      fb    = q_q[WIDTH-1] ^ mode;
      shift = {q_q[WIDTH-2:0], fb};
    end else begin
      fb    = q_q[0] ^ mode;
      shift = {fb, q_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (load) begin
      q_d = load_val;
    end else if (en) begin
`ifdef RC_SELF_CORRECT_EN
      if (illegal) begin
        q_d = INIT;
      end else begin
        q_d    = shift;
        wrap_d = (shift == INIT);
      end
`else
      q_d    = shift;
      wrap_d = (shift == INIT);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q    <= INIT;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign q    = q_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_ring_counter_gen.sv
// Self-checking bench for ring_counter_gen: directed scenarios plus
// randomized traffic against an arithmetic reference model.
module tb_ring_counter_gen;

  localparam int W = 4;
  localparam logic [W-1:0] INIT = 4'b0001;

  logic         clk = 1'b0;
  logic         reset, en, dir, mode, load;
  logic [W-1:0] load_val;
  logic [W-1:0] q;
  logic         wrap, illegal;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] m_q;
  logic         m_wrap;

  ring_counter_gen #(.WIDTH(W), .INIT(INIT)) dut (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .mode(mode),
    .load(load), .load_val(load_val),
    .q(q), .wrap(wrap), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_illegal(input logic [W-1:0] v, input logic m);
    logic [31:0] x;
    x = {28'd0, v};
    if (!m) return $countones(x) != 1;
    return $countones((x ^ (x >> 1)) & 32'(4'b0111)) > 1;
  endfunction

  function automatic logic [W-1:0] m_step(input logic [W-1:0] v,
                                          input logic d, input logic m);
    logic [31:0] x, b;
    x = {28'd0, v};
    if (!d) begin
      b = ((x >> (W - 1)) & 32'd1) ^ 32'(m);
      return W'((x << 1) | b);
    end
    b = (x & 32'd1) ^ 32'(m);
    return W'((x >> 1) | (b << (W - 1)));
  endfunction

  task automatic model(input logic r, input logic l, input logic e,
                       input logic d, input logic m, input logic [W-1:0] lv);
    logic [W-1:0] n;
    m_wrap = 1'b0;
    if (r) begin
      m_q = INIT;
    end else if (l) begin
      m_q = lv;
    end else if (e) begin
`ifdef RC_SELF_CORRECT_EN
      if (m_illegal(m_q, m)) begin
        m_q = INIT;
      end else begin
        n = m_step(m_q, d, m);
        m_wrap = (n == INIT);
        m_q = n;
      end
`else
      n = m_step(m_q, d, m);
      m_wrap = (n == INIT);
      m_q = n;
`endif
    end
  endtask

  task automatic cyc(input logic r, input logic l, input logic e,
                     input logic d, input logic m, input logic [W-1:0] lv);
    reset = r; load = l; en = e; dir = d; mode = m; load_val = lv;
    @(posedge clk);
    #1;
    model(r, l, e, d, m, lv);
    check("q", 32'(q), 32'(m_q));
    check("wrap", 32'(wrap), 32'(m_wrap));
    check("illegal", 32'(illegal), 32'(m_illegal(m_q, m)));
  endtask

  logic [W-1:0] t1 [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [W-1:0] t2 [8] = '{4'b0011, 4'b0111, 4'b1111, 4'b1110,
                           4'b1100, 4'b1000, 4'b0000, 4'b0001};
  logic [W-1:0] t3 [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};

  initial begin
    reset = 1'b0; en = 1'b0; dir = 1'b0; mode = 1'b0;
    load = 1'b0; load_val = '0;
    m_q = INIT; m_wrap = 1'b0;

    // 1: reset then ring-left
    cyc(1, 0, 1, 0, 0, 4'b0000);
    check("rst_q", 32'(q), 32'(4'b0001));
    check("rst_wrap", 32'(wrap), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, 0, 0, 4'b0000);
      check("t1_q", 32'(q), 32'(t1[i]));
      check("t1_wrap", 32'(wrap), 32'(i == 3));
      check("t1_ill", 32'(illegal), 32'd0);
    end

    // 2: Johnson left from 0001
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 1, 0, 1, 4'b0000);
      check("t2_q", 32'(q), 32'(t2[i]));
      check("t2_wrap", 32'(wrap), 32'(i == 7));
    end

    // 3: ring right then hold
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, 1, 0, 4'b0000);
      check("t3_q", 32'(q), 32'(t3[i]));
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1, 0, 4'b0000);
      check("t3_hold_q", 32'(q), 32'(4'b0001));
      check("t3_hold_wrap", 32'(wrap), 32'd0);
    end

    // 4: load wins over en; illegal per mode
    cyc(0, 1, 1, 0, 0, 4'b0110);
    check("t4_q", 32'(q), 32'(4'b0110));
    check("t4_wrap", 32'(wrap), 32'd0);
    check("t4_ill_ring", 32'(illegal), 32'd1);
    cyc(0, 0, 0, 0, 1, 4'b0000);
    check("t4_ill_john", 32'(illegal), 32'd1);
    cyc(0, 1, 0, 0, 1, 4'b0111);
    check("t4_ill_0111", 32'(illegal), 32'd0);

    // 5: step from illegal 0110 in ring mode
    cyc(0, 1, 0, 0, 0, 4'b0110);
    cyc(0, 0, 1, 0, 0, 4'b0000);
`ifdef RC_SELF_CORRECT_EN
    check("t5_q", 32'(q), 32'(4'b0001));
    check("t5_ill", 32'(illegal), 32'd0);
`else
    check("t5_q", 32'(q), 32'(4'b1100));
    check("t5_ill", 32'(illegal), 32'd1);
`endif
    check("t5_wrap", 32'(wrap), 32'd0);

    // 6: reset beats load and en mid-run
    cyc(1, 0, 0, 0, 0, 4'b0000);
    cyc(0, 0, 1, 0, 0, 4'b0000);
    cyc(0, 0, 1, 0, 0, 4'b0000);
    check("t6_pre", 32'(q), 32'(4'b0100));
    cyc(1, 1, 1, 0, 0, 4'b1111);
    check("t6_q", 32'(q), 32'(4'b0001));
    check("t6_wrap", 32'(wrap), 32'd0);

    // randomized traffic
    begin
      logic rm, rd;
      rm = 1'b0; rd = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(7) == 0) rm = ~rm;
        if ($urandom_range(5) == 0) rd = ~rd;
        cyc($urandom_range(63) == 0, $urandom_range(15) == 0,
            $urandom_range(3) != 0, rd, rm, W'($urandom));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
